dcw_cfg_sequencer: RTL and testbench

Configuration sequencer for the data channel wrapper (DCW) in the BERT data path. It accepts one channel-configuration request at a time from the host/control side and drives the DCW command bus (`ctrl_sig`, `val`, `val1`) through a fixed sequence: reset pulse, width load, aux load, settle, then optional width readback. It reports completion and error status to the requester.

---
 rtl/dcw_cfg_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_dcw_cfg_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcw_cfg_sequencer.sv
// Drives the DCW command bus through reset pulse, width load, aux load and settle for one request at a time.
// Optional width readback (CHECK state with timeout) is compiled in when DCW_SEQ_READBACK_EN is defined.
module dcw_cfg_sequencer #(
    parameter int RST_CYCLES     = 4,
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_width,
    input  logic [2:0] cfg_aux,
    output logic [2:0] ctrl_sig,
    output logic [2:0] val,
    output logic [2:0] val1,
    input  logic       channel_reset,
    input  logic [2:0] datawidth,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_WIDTH,
        S_AUX,
        S_SETTLE,
`ifdef DCW_SEQ_READBACK_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_RESET     = 3'd1;
    localparam logic [2:0] CMD_SET_WIDTH = 3'd2;
    localparam logic [2:0] CMD_SET_AUX   = 3'd3;

    localparam logic [7:0] RST_LOAD     = 8'(RST_CYCLES - 1);
    localparam logic [7:0] SETTLE_LOAD  = 8'(SETTLE_CYCLES - 1);
`ifdef DCW_SEQ_READBACK_EN
    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT_CYCLES - 1);
`endif

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_count;
    logic [7:0] w_nextCount;
    logic       w_doneErr;
    logic [2:0] r_width;
    logic [2:0] r_aux;

    logic       r_ready;
    logic [2:0] r_ctrl;
    logic [2:0] r_val;
    logic [2:0] r_val1;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic       w_ready;
    logic [2:0] w_ctrl;
    logic [2:0] w_val;
    logic [2:0] w_val1;
    logic       w_busy;
    logic       w_done;
    logic       w_err;

`ifndef DCW_SEQ_READBACK_EN
    logic w_unusedReadback;
    assign w_unusedReadback = ^{datawidth, channel_reset};
`endif

    // State, counter, latched request and all outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_width <= '0;
            r_aux   <= '0;
            r_ready <= 1'b1;
            r_ctrl  <= CMD_NOP;
            r_val   <= '0;
            r_val1  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (cfg_valid && r_ready) begin
                r_width <= cfg_width;
                r_aux   <= cfg_aux;
            end
            r_ready <= w_ready;
            r_ctrl  <= w_ctrl;
            r_val   <= w_val;
            r_val1  <= w_val1;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    // The counter is loaded with length-1 on entry and the state moves on when it hits zero.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_doneErr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid && r_ready) begin
                    if (cfg_width == 3'd0) begin
                        w_nextState = S_DONE;
                        w_doneErr   = 1'b1;
                    end else begin
                        w_nextState = S_RESET;
                        w_nextCount = RST_LOAD;
                    end
                end
            end
            S_RESET: begin
                if (r_count == 8'd0) w_nextState = S_WIDTH;
                else                 w_nextCount = r_count - 8'd1;
            end
            S_WIDTH: w_nextState = S_AUX;
            S_AUX: begin
                w_nextState = S_SETTLE;
                w_nextCount = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (r_count == 8'd0) begin
`ifdef DCW_SEQ_READBACK_EN
                    w_nextState = S_CHECK;
                    w_nextCount = TIMEOUT_LOAD;
`else
                    w_nextState = S_DONE;
`endif
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
`ifdef DCW_SEQ_READBACK_EN
            S_CHECK: begin
                if (datawidth == r_width && !channel_reset) begin
                    w_nextState = S_DONE;
                end else if (r_count == 8'd0) begin
                    w_nextState = S_DONE;
                    w_doneErr   = 1'b1;
                end else begin
                    w_nextCount = r_count - 8'd1;
                end
            end
`endif
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it once registered.
    always_comb begin
        w_ctrl  = CMD_NOP;
        w_val   = r_val;
        w_val1  = r_val1;
        w_done  = 1'b0;
        w_err   = 1'b0;
        w_ready = (w_nextState == S_IDLE);
        w_busy  = (w_nextState != S_IDLE);
        case (w_nextState)
            S_RESET: w_ctrl = CMD_RESET;
            S_WIDTH: begin
                w_ctrl = CMD_SET_WIDTH;
                w_val  = r_width;
            end
            S_AUX: begin
                w_ctrl = CMD_SET_AUX;
                w_val1 = r_aux;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_err  = w_doneErr;
            end
            default: w_ctrl = CMD_NOP;
        endcase
    end

    assign cfg_ready = r_ready;
    assign ctrl_sig  = r_ctrl;
    assign val       = r_val;
    assign val1      = r_val1;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_dcw_cfg_sequencer.sv
// Self-checking bench for dcw_cfg_sequencer: offset-based behavioural model checked every cycle,
// plus directed sequences with literal timing expectations. Honours DCW_SEQ_READBACK_EN like the design.
module tb_dcw_cfg_sequencer;

    localparam int R    = 4;
    localparam int S    = 8;
    localparam int TO   = 16;
    localparam int CHK0 = R + S + 3;
`ifdef DCW_SEQ_READBACK_EN
    localparam bit RDBK   = 1'b1;
    localparam int DONE_K = R + S + 4;
`else
    localparam bit RDBK   = 1'b0;
    localparam int DONE_K = R + S + 3;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [2:0] cfg_width = 3'd0;
    logic [2:0] cfg_aux = 3'd0;
    logic       channel_reset = 1'b0;
    logic [2:0] datawidth = 3'd0;
    logic       cfg_ready;
    logic [2:0] ctrl_sig;
    logic [2:0] val;
    logic [2:0] val1;
    logic       busy;
    logic       done;
    logic       err;

    int total = 0;
    int bad = 0;
    int dutAccepts = 0;
    bit countAccepts = 1'b0;
    logic prevReady = 1'b1;

    // Model state: mK is the cycle offset since the accepting edge, 0 while idle.
    int         mK = 0;
    bit         mDoneNow = 1'b0;
    bit         mErr = 1'b0;
    logic [2:0] mW = 3'd0;
    logic [2:0] mA = 3'd0;
    logic [2:0] mVal = 3'd0;
    logic [2:0] mVal1 = 3'd0;

    dcw_cfg_sequencer #(
        .RST_CYCLES    (R),
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_width    (cfg_width),
        .cfg_aux      (cfg_aux),
        .ctrl_sig     (ctrl_sig),
        .val          (val),
        .val1         (val1),
        .channel_reset(channel_reset),
        .datawidth    (datawidth),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [2:0] w, input logic [2:0] a);
        cfg_valid = v;
        cfg_width = w;
        cfg_aux   = a;
    endtask

    task automatic modelStep(input bit rst, input bit vld, input logic [2:0] w, input logic [2:0] a,
                             input logic [2:0] dw, input bit chr);
        bit match;
        if (rst) begin
            mK = 0; mDoneNow = 1'b0; mErr = 1'b0; mVal = 3'd0; mVal1 = 3'd0;
        end else if (mDoneNow) begin
            mDoneNow = 1'b0;
            mK = 0;
        end else if (mK == 0) begin
            if (vld) begin
                mW = w; mA = a; mK = 1;
                if (w == 3'd0) begin mDoneNow = 1'b1; mErr = 1'b1; end
            end
        end else if (RDBK && mK >= CHK0) begin
            match = (dw == mW) && !chr;
            if (match || (mK - CHK0) == TO - 1) begin
                mDoneNow = 1'b1;
                mErr = !match;
            end
            mK++;
        end else begin
            mK++;
            if (mK == R + 1) mVal = mW;
            if (mK == R + 2) mVal1 = mA;
            if (!RDBK && mK == CHK0) begin mDoneNow = 1'b1; mErr = 1'b0; end
        end
    endtask

    function automatic int expCtrl();
        if (mDoneNow || mK == 0) return 0;
        if (mK <= R)     return 1;
        if (mK == R + 1) return 2;
        if (mK == R + 2) return 3;
        return 0;
    endfunction

    // Every edge: advance the model with the sampled inputs, then compare all outputs.
    initial begin : compareLoop
        forever begin
            @(posedge clock);
            if (countAccepts && !reset && cfg_valid && prevReady) dutAccepts++;
            modelStep(reset, cfg_valid, cfg_width, cfg_aux, datawidth, channel_reset);
            #1;
            checkOutput("m_ctrl",  int'(ctrl_sig),  expCtrl());
            checkOutput("m_val",   int'(val),       int'(mVal));
            checkOutput("m_val1",  int'(val1),      int'(mVal1));
            checkOutput("m_busy",  int'(busy),      int'(mK != 0));
            checkOutput("m_ready", int'(cfg_ready), int'(mK == 0));
            checkOutput("m_done",  int'(done),      int'(mDoneNow));
            checkOutput("m_err",   int'(err),       int'(mDoneNow && mErr));
            prevReady = cfg_ready;
        end
    end

    initial begin : driver
        repeat (3) @(negedge clock);
        checkOutput("rst_ready", int'(cfg_ready), 1);
        checkOutput("rst_busy",  int'(busy), 0);
        checkOutput("rst_ctrl",  int'(ctrl_sig), 0);
        checkOutput("rst_done",  int'(done), 0);
        reset = 1'b0;
        @(negedge clock);

        // Normal sequence width=7 aux=5 with matching readback.
        datawidth = 3'd7;
        channel_reset = 1'b0;
        applyStimulus(1'b1, 3'd7, 3'd5);
        for (int k = 1; k <= DONE_K + 2; k++) begin
            @(negedge clock);
            if (k == 1) cfg_valid = 1'b0;
            if (k <= R) checkOutput("t1_ctrl_reset", int'(ctrl_sig), 1);
            if (k == R + 1) begin
                checkOutput("t1_ctrl_width", int'(ctrl_sig), 2);
                checkOutput("t1_val", int'(val), 7);
            end
            if (k == R + 2) begin
                checkOutput("t1_ctrl_aux", int'(ctrl_sig), 3);
                checkOutput("t1_val1", int'(val1), 5);
            end
            if (k >= R + 3 && k <= R + 2 + S) checkOutput("t1_ctrl_nop", int'(ctrl_sig), 0);
            if (k == DONE_K) begin
                checkOutput("t1_done", int'(done), 1);
                checkOutput("t1_err", int'(err), 0);
            end else begin
                checkOutput("t1_no_done", int'(done), 0);
            end
        end

        // Illegal width.
        applyStimulus(1'b1, 3'd0, 3'd3);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) begin
                cfg_valid = 1'b0;
                checkOutput("ill_done", int'(done), 1);
                checkOutput("ill_err", int'(err), 1);
            end
            checkOutput("ill_ctrl", int'(ctrl_sig), 0);
            if (k == 2) checkOutput("ill_ready", int'(cfg_ready), 1);
        end

`ifdef DCW_SEQ_READBACK_EN
        // Readback never matches: timeout error.
        datawidth = 3'd2;
        applyStimulus(1'b1, 3'd3, 3'd1);
        for (int k = 1; k <= R + S + 3 + TO + 1; k++) begin
            @(negedge clock);
            if (k == 1) cfg_valid = 1'b0;
            if (k == R + S + 3 + TO) begin
                checkOutput("to_done", int'(done), 1);
                checkOutput("to_err", int'(err), 1);
            end else begin
                checkOutput("to_no_done", int'(done), 0);
            end
        end
`else
        // Readback absent: datawidth ignored.
        datawidth = 3'd0;
        applyStimulus(1'b1, 3'd6, 3'd4);
        for (int k = 1; k <= R + S + 4; k++) begin
            @(negedge clock);
            if (k == 1) cfg_valid = 1'b0;
            if (k == R + S + 3) begin
                checkOutput("nr_done", int'(done), 1);
                checkOutput("nr_err", int'(err), 0);
            end
        end
`endif

        // Reset during AUX: everything returns to reset values, no done.
        datawidth = 3'd5;
        applyStimulus(1'b1, 3'd5, 3'd2);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            if (k == 1) cfg_valid = 1'b0;
            if (k == 6) begin
                checkOutput("mr_ctrl_aux", int'(ctrl_sig), 3);
                reset = 1'b1;
            end
            if (k == 7) begin
                checkOutput("mr_ctrl", int'(ctrl_sig), 0);
                checkOutput("mr_val", int'(val), 0);
                checkOutput("mr_val1", int'(val1), 0);
                checkOutput("mr_busy", int'(busy), 0);
                checkOutput("mr_ready", int'(cfg_ready), 1);
                reset = 1'b0;
            end
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clock);
            checkOutput("mr_no_done", int'(done), 0);
        end

        // Valid held for 30 edges: exactly two accepts.
        datawidth = 3'd4;
        dutAccepts = 0;
        countAccepts = 1'b1;
        applyStimulus(1'b1, 3'd4, 3'd6);
        repeat (30) @(negedge clock);
        cfg_valid = 1'b0;
        countAccepts = 1'b0;
        checkOutput("busy_accepts", dutAccepts, 2);
        repeat (DONE_K + 4) @(negedge clock);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            cfg_valid     = ($urandom_range(0, 1) == 1);
            cfg_width     = 3'($urandom_range(0, 7));
            cfg_aux       = 3'($urandom_range(0, 7));
            channel_reset = ($urandom_range(0, 3) == 0);
            datawidth     = ($urandom_range(0, 1) == 1) ? mW : 3'($urandom_range(0, 7));
            @(negedge clock);
        end
        reset = 1'b0;
        cfg_valid = 1'b0;
        repeat (5) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
